fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 84 ++++++++
 tb/tb_fifo_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Drains an upstream FIFO with one-cycle read latency into a 2-entry registered output stream.
// Read requests are throttled so a word in flight always has a buffer slot waiting for it.
module fifo_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic       pop;
  logic [2:0] level_after;
  logic [1:0] remain;

  assign pop = valid_q & m_ready;

  // Buffer level after this edge if no new read is issued; pop implies occ_q >= 1.
  assign level_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign remain      = occ_q - {1'b0, pop};

  assign fifo_r_en = rst_n & en & ~fifo_empty & (level_after < 3'd2);

  always_comb begin
    occ_d  = level_after[1:0];
    head_d = head_q;
    tail_d = tail_q;
    // Only shift when a second word exists, so head keeps the last word once emptied.
    if (pop && (occ_q == 2'd2)) begin
      head_d = tail_q;
    end
    if (inflight_q) begin
      if (remain == 2'd0) begin
        head_d = fifo_data;
      end else begin
        tail_d = fifo_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_r_en;
      valid_q    <= (occ_d != 2'd0);
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (pop) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign m_valid    = valid_q;
  assign m_data     = head_q;
  assign busy       = (occ_q != 2'd0) | inflight_q;
  assign xfer_count = cnt_q;

  occupancy_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: directed scenarios plus random traffic, with a negedge monitor that
// scores the output stream against the upstream word sequence.
module tb_fifo_reader;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_empty;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] xfer_count;

  // Upstream FIFO contents double as the expected output sequence.
  logic [DW-1:0] words [0:4095];
  int wr_ptr = 0;
  int up_rd = 0;
  int exp_rd = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int t0, first, run, pulses, pops;

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == up_rd);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_r_en) begin
      fifo_data <= words[up_rd];
      up_rd     <= up_rd + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    words[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Words read but not yet delivered equal occ + inflight; reset forfeits them.
  task automatic monitor();
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            cnt_m = 0;
    int            outstanding;
    logic          pop;
    logic          exp_ren;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("ren_in_reset", fifo_r_en, 0);
        exp_rd     = up_rd;
        cnt_m      = 0;
        prev_stall = 1'b0;
      end else begin
        pop         = m_valid & m_ready;
        outstanding = up_rd - exp_rd;
        check("occupancy_bound", outstanding <= 2, 1);
        check("busy", busy, outstanding != 0);
        exp_ren = en && !fifo_empty && ((outstanding - int'(pop)) < 2);
        check("fifo_r_en", fifo_r_en, exp_ren);
        check("xfer_count", xfer_count, cnt_m % 16);
        if (prev_stall) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, prev_data);
        end
        if (pop) begin
          check("pop_has_word", outstanding > 0, 1);
          check("order_data", m_data, words[exp_rd]);
          exp_rd++;
          cnt_m++;
        end
        prev_stall = m_valid & !m_ready;
        prev_data  = m_data;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    step(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_valid", m_valid, 0);
    check("reset_data", m_data, 0);
    check("reset_busy", busy, 0);
    check("reset_count", xfer_count, 0);

    // Streaming 0x11..0x18 with m_ready held high
    step(1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
    en = 1'b1;
    @(negedge clk);
    t0 = cyc;
    check("stream_ren_start", fifo_r_en, 1);
    first = -1;
    run   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_valid) begin
        if (first < 0) first = cyc;
        run++;
      end else if (first >= 0) begin
        break;
      end
    end
    check("stream_latency", first - t0, 2);
    check("stream_run", run, 8);
    check("stream_count", xfer_count, 8);
    check("stream_idle_busy", busy, 0);

    // Backpressure: 4 words, m_ready low for 10 cycles
    step(1);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
    step(10);
    @(negedge clk);
    check("bp_ren", fifo_r_en, 0);
    check("bp_valid", m_valid, 1);
    check("bp_data", m_data, 8'h11);
    check("bp_busy", busy, 1);
    step(1);
    m_ready = 1'b1;
    run = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) run++;
      else break;
    end
    check("bp_run", run, 4);
    check("bp_count", xfer_count, 12);

    // Empty upstream FIFO
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("empty_ren", fifo_r_en, 0);
      check("empty_valid", m_valid, 0);
      check("empty_busy", busy, 0);
    end

    // en dropped the cycle after a read request
    step(1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h31 + i));
    step(2);
    en = 1'b1;
    @(negedge clk);
    check("endrop_ren", fifo_r_en, 1);
    step(1);
    en = 1'b0;
    pulses = 0;
    pops   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (fifo_r_en) pulses++;
      if (m_valid && m_ready) pops++;
    end
    check("endrop_pulses", pulses, 0);
    check("endrop_delivered", pops, 1);
    check("endrop_busy", busy, 0);

    // Reset with a full buffer
    step(1);
    m_ready = 1'b0;
    en = 1'b1;
    push(8'h35);
    step(4);
    @(negedge clk);
    check("prereset_valid", m_valid, 1);
    check("prereset_busy", busy, 1);
    step(1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_ren", fifo_r_en, 0);
    @(negedge clk);
    check("postreset_valid", m_valid, 0);
    check("postreset_data", m_data, 0);
    check("postreset_busy", busy, 0);
    check("postreset_count", xfer_count, 0);
    step(1);
    rst_n = 1'b1;

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      step(1);
      if ($urandom_range(0, 2) != 0) push(8'($urandom));
      en      = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
    end
    en      = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (exp_rd == wr_ptr) break;
      step(1);
    end
    check("drain_complete", exp_rd, wr_ptr);

    // Counter wrap: 17 transfers on a 4-bit counter
    step(1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
    for (int k = 0; k < 100; k++) begin
      if (exp_rd == wr_ptr) break;
      step(1);
    end
    step(1);
    @(negedge clk);
    check("wrap_count", xfer_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
